// File: rtl/line_clear_scanner.sv
// Post-lock line clear: scans the board RAM bottom-up, compacts survivors, zero-fills the top, then strobes hit.
// Optional LINE_TOTAL_EN adds a saturating 3-digit BCD running total of cleared lines.
module line_clear_scanner #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ROW_AW = 5,
  parameter int HIT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROW_AW-1:0] row_addr,
  input  logic [COLS-1:0]   row_rdata,
  output logic [COLS-1:0]   row_wdata,
  output logic              row_we,
  output logic              hit,
`ifdef LINE_TOTAL_EN
  output logic [11:0]       total_lines,
`endif
  output logic [1:0]        line_count
);

  localparam int HW = (HIT_W > 1) ? $clog2(HIT_W) : 1;
  localparam logic [ROW_AW:0]   WP_END  = (ROW_AW+1)'(ROWS);
  localparam logic [ROW_AW-1:0] RP_LAST = ROW_AW'(ROWS - 1);
  localparam logic [HW-1:0]     H_LAST  = HW'(HIT_W - 1);

  typedef enum logic [2:0] {IDLE, RD, EV, FILL, REP_SETUP, REP_HIT, FIN} state_t;

  state_t            state, nxt;
  logic [ROW_AW-1:0] rp, rp_n, addr_q;
  logic [ROW_AW:0]   wp, wp_n;
  logic [2:0]        n, n_n;
  logic [HW-1:0]     hcnt, hcnt_n;
  logic              full;

  assign full = &row_rdata;

  always_comb begin
    nxt       = state;
    row_addr  = addr_q;
    row_wdata = '0;
    row_we    = 1'b0;
    rp_n      = rp;
    wp_n      = wp;
    n_n       = n;
    hcnt_n    = hcnt;
    case (state)
      IDLE: begin
        if (start) begin
          rp_n = '0;
          wp_n = '0;
          n_n  = '0;
          nxt  = RD;
        end
      end
      RD: begin
        row_addr = rp;
        nxt      = EV;
      end
      EV: begin
        row_addr = rp;
        if (full) begin
          if (n != 3'd7) n_n = n + 3'd1;
        end else begin
          // wp trails rp, so this write only ever lands on an already-read row
          if (wp != {1'b0, rp}) begin
            row_addr  = wp[ROW_AW-1:0];
            row_wdata = row_rdata;
            row_we    = 1'b1;
          end
          wp_n = wp + 1'b1;
        end
        if (rp == RP_LAST) begin
          nxt = FILL;
        end else begin
          rp_n = rp + 1'b1;
          nxt  = RD;
        end
      end
      FILL: begin
        if (wp == WP_END) begin
          nxt = (n != 3'd0) ? REP_SETUP : FIN;
        end else begin
          row_addr = wp[ROW_AW-1:0];
          row_we   = 1'b1;
          wp_n     = wp + 1'b1;
        end
      end
      REP_SETUP: begin
        hcnt_n = '0;
        nxt    = REP_HIT;
      end
      REP_HIT: begin
        if (hcnt == H_LAST) nxt = FIN;
        else                hcnt_n = hcnt + 1'b1;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

`ifdef LINE_TOTAL_EN
  function automatic logic [11:0] bcd_add(input logic [11:0] t, input logic [2:0] k);
    logic [11:0] r;
    logic [4:0]  s;
    logic [4:0]  c;
    r = '0;
    c = {2'b00, k};
    for (int unsigned i = 0; i < 3; i++) begin
      s = 5'(t[i*4 +: 4]) + c;
      if (s > 5'd9) begin
        r[i*4 +: 4] = 4'(s - 5'd10);
        c = 5'd1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        c = 5'd0;
      end
    end
    if (c != 5'd0) r = 12'h999;
    return r;
  endfunction
`endif

  // Strobes are registered on the next state so hit/done/busy are glitch-free flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rp         <= '0;
      wp         <= '0;
      n          <= '0;
      hcnt       <= '0;
      addr_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit        <= 1'b0;
      line_count <= '0;
`ifdef LINE_TOTAL_EN
      total_lines <= '0;
`endif
    end else begin
      state  <= nxt;
      rp     <= rp_n;
      wp     <= wp_n;
      n      <= n_n;
      hcnt   <= hcnt_n;
      addr_q <= row_addr;
      busy   <= (nxt != IDLE);
      done   <= (nxt == FIN);
      hit    <= (nxt == REP_HIT);
      // loaded on entry to REP_SETUP so it settles a cycle ahead of hit
      if (state == FILL && nxt == REP_SETUP)
        line_count <= (n >= 3'd4) ? 2'd3 : (n[1:0] - 2'd1);
`ifdef LINE_TOTAL_EN
      if (state == REP_SETUP)
        total_lines <= bcd_add(total_lines, (n >= 3'd4) ? 3'd4 : n);
`endif
    end
  end

endmodule

// File: tb/tb_line_clear_scanner.sv
// Scoreboarded bench for line_clear_scanner: random and directed boards against a row-list reference model.
module tb_line_clear_scanner;
  localparam int ROWS = 20, COLS = 10, ROW_AW = 5, HIT_W = 2;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic              busy, done, row_we, hit;
  logic [ROW_AW-1:0] row_addr;
  logic [COLS-1:0]   row_rdata, row_wdata;
  logic [1:0]        line_count;
`ifdef LINE_TOTAL_EN
  logic [11:0]       total_lines;
`endif

  always #5 clk = ~clk;

  line_clear_scanner #(.ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW), .HIT_W(HIT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .row_addr(row_addr), .row_rdata(row_rdata), .row_wdata(row_wdata),
    .row_we(row_we), .hit(hit),
`ifdef LINE_TOTAL_EN
    .total_lines(total_lines),
`endif
    .line_count(line_count)
  );

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] pre [ROWS];
  logic            load = 1'b0;

  always @(posedge clk) begin
    if (load) for (int i = 0; i < ROWS; i++) mem[i] <= pre[i];
    else if (row_we) mem[int'(row_addr)] <= row_wdata;
    row_rdata <= mem[int'(row_addr)];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned             sc;
    int unsigned             lat;
    int                      k;
    int                      lc;
    int                      writes;
    int                      tot;
    logic [ROWS*COLS-1:0]    board;
  } txn_t;

  txn_t q[$];
  int n_cmp = 0, n_bad = 0;
  int mon_done = 0, hit_total = 0, tot_model = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int bcd_val(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Reference: drop full rows, keep the rest in order, pad with empty rows on top
  task automatic model_of(input int unsigned sc, output txn_t t);
    logic [COLS-1:0] surv[$];
    int              orig[$];
    int              k;
    k = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (pre[r] == '1) k++;
      else begin
        surv.push_back(pre[r]);
        orig.push_back(r);
      end
    end
    t.board  = '0;
    t.writes = k;
    for (int i = 0; i < surv.size(); i++) begin
      t.board[i*COLS +: COLS] = surv[i];
      if (orig[i] != i) t.writes++;
    end
    t.k   = k;
    t.lc  = (k == 0) ? 0 : ((k > 4) ? 3 : k - 1);
    t.lat = (k == 0) ? 2*ROWS + 2 : 2*ROWS + k + HIT_W + 3;
    if (k > 0) begin
      tot_model = tot_model + ((k > 4) ? 4 : k);
      if (tot_model > 999) tot_model = 999;
    end
    t.tot = tot_model;
    t.sc  = sc;
  endtask

  int              wr_cnt = 0, hit_cyc = 0, busy_low = 0;
  logic            prev_hit = 1'b0;
  logic [1:0]      prev_lc = '0;
  txn_t            mt;
  logic [ROWS*COLS-1:0] act_board;

  always @(negedge clk) begin
    if (rst) begin
      wr_cnt = 0; hit_cyc = 0; busy_low = 0;
      prev_hit = 1'b0; prev_lc = line_count;
    end else begin
      if (row_we) wr_cnt++;
      if (hit) begin hit_cyc++; hit_total++; end
      if (q.size() > 0 && cyc > q[0].sc && !busy) busy_low++;
      if (hit && !prev_hit && q.size() > 0 && q[0].k > 0) begin
        chk("line_count_before_hit", prev_lc, q[0].lc);
        chk("line_count_at_hit", line_count, q[0].lc);
      end
      if (done) begin
        if (q.size() == 0) chk("spurious_done", done, 0);
        else begin
          mt = q.pop_front();
          chk("latency", cyc - mt.sc, mt.lat);
          chk("busy_at_done", busy, 1);
          chk("busy_gaps", busy_low, 0);
          chk("write_count", wr_cnt, mt.writes);
          chk("hit_cycles", hit_cyc, (mt.k > 0) ? HIT_W : 0);
          if (mt.k > 0) chk("line_count_hold", line_count, mt.lc);
`ifdef LINE_TOTAL_EN
          chk("total_lines", bcd_val(total_lines), mt.tot);
`endif
          for (int i = 0; i < ROWS; i++) act_board[i*COLS +: COLS] = mem[i];
          n_cmp++;
          if (act_board !== mt.board) begin
            n_bad++;
            $display("FAIL board: got %h expected %h", act_board, mt.board);
          end
        end
        wr_cnt = 0; hit_cyc = 0; busy_low = 0;
        mon_done++;
      end
      prev_hit = hit;
      prev_lc  = line_count;
    end
  end

  task automatic load_board();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic launch(input bit extra);
    txn_t t;
    int   base, w;
    base = mon_done;
    model_of(cyc, t);
    q.push_back(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (extra) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    w = 0;
    while (mon_done == base && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (mon_done == base) begin
      chk("done_timeout", mon_done - base, 1);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic clear_pre();
    for (int r = 0; r < ROWS; r++) pre[r] = '0;
  endtask

  task automatic gen_random(input int kmax);
    int kf, placed, r;
    for (int i = 0; i < ROWS; i++) begin
      pre[i] = COLS'($urandom);
      if (pre[i] == '1) pre[i][0] = 1'b0;
    end
    kf = $urandom_range(0, kmax);
    placed = 0;
    while (placed < kf) begin
      r = $urandom_range(0, ROWS - 1);
      if (pre[r] != '1) begin
        pre[r] = '1;
        placed++;
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_row_we"}, row_we, 0);
    chk({tag, "_row_addr"}, row_addr, 0);
    chk({tag, "_row_wdata"}, row_wdata, 0);
    chk({tag, "_line_count"}, line_count, 0);
`ifdef LINE_TOTAL_EN
    chk({tag, "_total"}, total_lines, 0);
`endif
  endtask

  initial begin
    int h0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    clear_pre();
    load_board();
    launch(1'b0);

    clear_pre();
    pre[0] = '1; pre[1] = 10'h001; pre[2] = 10'h001; pre[3] = 10'h001;
    load_board();
    launch(1'b0);

    clear_pre();
    for (int r = 0; r < 4; r++) pre[r] = '1;
    pre[4] = 10'h155;
    load_board();
    launch(1'b0);

    for (int r = 0; r < ROWS; r++) pre[r] = COLS'(r * 37 + 1);
    pre[5] = '1; pre[7] = '1;
    load_board();
    launch(1'b0);

    for (int i = 0; i < 30; i++) begin
      gen_random(6);
      load_board();
      launch(1'($urandom_range(0, 1)));
    end

    // abort: second start mid-scan is dropped, then reset lands ten cycles in
    gen_random(3);
    pre[2] = '1;
    load_board();
    h0 = hit_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("abort");
    tot_model = 0;
    gen_random(4);
    load_board();
    @(negedge clk);
    chk("abort_no_hit", hit_total - h0, 0);
    chk("abort_no_done", mon_done, 34);
    rst = 1'b0;
    launch(1'b0);

`ifdef LINE_TOTAL_EN
    clear_pre();
    for (int r = 0; r < 4; r++) pre[r] = '1;
    for (int i = 0; i < 252; i++) begin
      load_board();
      launch(1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
